// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one input clock,
// with deferred divisor updates applied on period boundaries and per-channel lock.
module clk_div_bank #(
   parameter int NUM_CH   = 2,
   parameter int DIV_W    = 8,
   parameter int INIT_DIV = 4,
   parameter int LOCK_CNT = 16,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [DIV_W-1:0]  wr_div,
   output logic [NUM_CH-1:0] clkout,
   output logic [NUM_CH-1:0] ce,
   output logic [NUM_CH-1:0] pend,
   output logic [NUM_CH-1:0] lock
);

   localparam int LW = $clog2(LOCK_CNT + 1);

   logic [DIV_W-1:0] wr_val;

   assign wr_val = (wr_div < DIV_W'(2)) ? DIV_W'(2) : wr_div;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DIV_W-1:0] div_q, div_n, pdiv_q, pdiv_n, cnt_q, cnt_n;
      logic [LW-1:0]    lcnt_q, lcnt_n;
      logic             pend_q, pend_n, lock_q, lock_n, run_q;
      logic             clk_q, clk_n, ce_q, ce_n, hit, wrap;

      assign hit  = wr_en && (wr_ch == CH_W'(g));
      assign wrap = (cnt_q == div_q - DIV_W'(1));

      always_comb begin
         div_n  = div_q;
         pdiv_n = pdiv_q;
         pend_n = pend_q;
         lcnt_n = lcnt_q;
         lock_n = lock_q;
         cnt_n  = cnt_q + DIV_W'(1);
         if (wrap) begin
            cnt_n = '0;
            if (pend_q) begin
               div_n  = pdiv_q;
               pend_n = 1'b0;
            end
            // The wrap that leaves reset starts period 1 rather than ending one,
            // so run_q keeps it out of the completed-period count.
            if (pend_q && (pdiv_q != div_q)) begin
               lcnt_n = '0;
               lock_n = 1'b0;
            end else if (run_q && (lcnt_q != LW'(LOCK_CNT))) begin
               lcnt_n = lcnt_q + LW'(1);
               if (lcnt_q == LW'(LOCK_CNT - 1))
                  lock_n = 1'b1;
            end
         end
         if (hit) begin
            pdiv_n = wr_val;
            pend_n = 1'b1;
         end
         clk_n = (cnt_n < (div_n >> 1));
         ce_n  = (cnt_n == '0);
      end

      always_ff @(posedge clkin or posedge reset) begin
         if (reset) begin
            div_q  <= DIV_W'(INIT_DIV);
            cnt_q  <= DIV_W'(INIT_DIV - 1);
            pdiv_q <= '0;
            pend_q <= 1'b0;
            lcnt_q <= '0;
            lock_q <= 1'b0;
            run_q  <= 1'b0;
            clk_q  <= 1'b0;
            ce_q   <= 1'b0;
         end else begin
            div_q  <= div_n;
            cnt_q  <= cnt_n;
            pdiv_q <= pdiv_n;
            pend_q <= pend_n;
            lcnt_q <= lcnt_n;
            lock_q <= lock_n;
            run_q  <= 1'b1;
            clk_q  <= clk_n;
            ce_q   <= ce_n;
         end
      end

      assign clkout[g] = clk_q;
      assign ce[g]     = ce_q;
      assign pend[g]   = pend_q;
      assign lock[g]   = lock_q;
   end

endmodule
